cpu_ram_dma: RTL and testbench
==============================

# cpu_ram_dma

Parametrised successor to the CPU work RAM: a single-port synchronous RAM with CPU-bus address mirroring, active-low write, optional hex preload, and a built-in sprite (OAM) DMA engine. On a DMA request it stalls the CPU and copies `DMA_LEN` bytes from one 256-byte RAM page to the PPU OAM port. It sits on the CPU bus between the CPU core and the PPU.

## Interface
Parameters:
- `DATA_W`, 8, data width in bits.
- `ADDR_W`, 11, RAM index width; the RAM holds 2^`ADDR_W` words.
- `CPU_ADDR_W`, 16, CPU bus address width.
- `DMA_LEN`, 256, bytes copied per DMA; a power of 2 and ≤ 256.
- `INIT_FILE`, "", hex preload file; if empty, no preload.

Ports (single clock domain `Clk`; reset is asynchronous and active-high, named `Reset`):
- `Clk` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high.
- `cpu_addr` in `CPU_ADDR_W`: CPU address.
- `WE` in 1: active-low CPU write enable.
- `cpu_wdata` in `DATA_W`: CPU write data.
- `cpu_rdata` out `DATA_W`: registered read data.
- `dma_start` in 1: one-cycle DMA request.
- `dma_page` in 8: source page, sampled with `dma_start`.
- `cpu_stall` out 1: high while DMA owns the RAM.
- `oam_addr` out 8: OAM destination index.
- `oam_data` out `DATA_W`: OAM write data.
- `oam_we` out 1: active-high, one-cycle OAM write strobe.

## Operation
- RAM index = `cpu_addr[ADDR_W-1:0]`, so upper bits mirror. Address decode is external.
- CPU port (state IDLE only):
  - `WE`=0 writes `cpu_wdata` at the index.
  - Every cycle, `cpu_rdata` registers the old contents at the index (read-first; a write and read to the same address returns the pre-write value).
- Parity bit toggles every cycle; reset value 0.
- FSM states: IDLE, ALIGN, READ, WRITE.
  - IDLE, `dma_start`=1: latch `dma_page`, latch `odd` = parity, clear `idx`, go to ALIGN.
  - ALIGN: stays 1 cycle if `odd`=0, 2 cycles if `odd`=1, then goes to READ.
  - READ: RAM index = `{dma_page, idx}[ADDR_W-1:0]`, which mirrors the page. Read data is registered. Go to WRITE.
  - WRITE: `oam_we`=1, `oam_addr`=`idx`, `oam_data`=read data. If `idx`=`DMA_LEN`-1, go to IDLE; otherwise `idx`+1 and go to READ.
- `cpu_stall` = (state != IDLE).
  - While stalled, `WE` and `cpu_addr` are ignored and no CPU write occurs.
  - While stalled, `cpu_rdata` carries the DMA read register.
- `dma_start` while not IDLE is ignored and is not queued.
- `idx` is 8 bits wide and never wraps mid-transfer; termination is by compare.
- RAM contents are not cleared by `Reset`. Preload is applied only at configuration.

## Timing
- Reset values: state IDLE, `cpu_stall`=0, `oam_we`=0, `oam_addr`=0, `oam_data`=0, `cpu_rdata`=0, parity 0, `idx` 0.
- CPU read latency is 1 cycle: address at edge k gives data valid after edge k.
- CPU write takes effect at edge k and is visible to a read at edge k+1.
- `dma_start` is sampled at edge k. `cpu_stall` goes high after edge k.
- Total stall cycles = 1 + `odd` + 2·`DMA_LEN`. With defaults this is 513 (even start) or 514 (odd start).
- `oam_we` pulses every second cycle with no gaps between bytes.
- `cpu_stall` falls after the edge that completes the last WRITE cycle. The first CPU access is accepted at the next edge.
- `Reset` asserted mid-DMA: everything returns to reset values immediately. The partial OAM copy is not rolled back.
- `Reset` asserted during a CPU write cycle: the write is aborted and the addressed word is unspecified.

## Test plan
- CPU write 0xA5 at 0x0123, then read 0x0923 (mirror) → `cpu_rdata`=0xA5 one cycle later.
- Same-cycle write 0x5A / read at 0x0010, which held 0x11 → `cpu_rdata`=0x11; the next read returns 0x5A.
- Fill page 2 with byte i = i^0xFF. `dma_start` with page 0x02 on an even-parity cycle → 513 stall cycles, 256 `oam_we` pulses, `oam_addr` 0..255 in order, `oam_data`=~`oam_addr`.
- Same DMA started on an odd-parity cycle → 514 stall cycles; the first `oam_we` comes 3 cycles after the start edge.
- During DMA, drive `WE`=0 at 0x0200 with 0x00, and pulse `dma_start` again → RAM unchanged, exactly one transfer completes.
- Assert `Reset` after 40 OAM writes → `cpu_stall`=0 and `oam_we`=0 immediately, and RAM contents are intact on readback.

Source files
------------

// File: rtl/cpu_ram_dma.sv
// cpu_ram_dma
//   CPU work RAM with a built-in sprite (OAM) DMA engine. The RAM is a
//   single-port synchronous array indexed by the low ADDR_W bits of the CPU
//   address, so upper address bits mirror. A one-cycle dma_start stalls the CPU
//   and copies DMA_LEN bytes from a 256-byte page to the PPU OAM port. Each byte
//   takes one READ cycle followed by one WRITE cycle.
//
// Ports
//   Clk, Reset        clock; asynchronous active-high reset
//   cpu_addr          CPU bus address (low ADDR_W bits index the RAM)
//   WE                active-low CPU write enable
//   cpu_wdata         CPU write data
//   cpu_rdata         registered read data (read-first); DMA read data while stalled
//   dma_start         one-cycle DMA request, with source page dma_page
//   cpu_stall         high while the DMA engine owns the RAM
//   oam_addr/data/we  OAM write port; oam_we is a one-cycle strobe per byte
module cpu_ram_dma #(
  parameter int    DATA_W     = 8,
  parameter int    ADDR_W     = 11,
  parameter int    CPU_ADDR_W = 16,
  parameter int    DMA_LEN    = 256,
  parameter string INIT_FILE  = ""
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [CPU_ADDR_W-1:0] cpu_addr,
  input  logic                  WE,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dma_start,
  input  logic [7:0]            dma_page,
  output logic                  cpu_stall,
  output logic [7:0]            oam_addr,
  output logic [DATA_W-1:0]     oam_data,
  output logic                  oam_we
);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_READ, S_WRITE} state_e;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q,    state_d;
  logic              parity_q,   parity_d;
  logic              odd_q,      odd_d;
  logic [7:0]        page_q,     page_d;
  logic [7:0]        idx_q,      idx_d;
  logic              stall_q,    stall_d;
  logic              oam_we_q,   oam_we_d;
  logic [7:0]        oam_addr_q, oam_addr_d;
  logic [DATA_W-1:0] oam_data_q, oam_data_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;

  logic [ADDR_W-1:0] cpu_idx;
  logic [ADDR_W-1:0] dma_idx;
  logic [ADDR_W-1:0] ram_idx;
  logic [DATA_W-1:0] ram_rd;
  logic              ram_we;

  // Upper CPU address bits only exist to be mirrored away.
  logic cpu_addr_unused;
  assign cpu_addr_unused = ^cpu_addr[CPU_ADDR_W-1:ADDR_W];

  assign cpu_idx = cpu_addr[ADDR_W-1:0];
  // {page, idx} truncated to the RAM width, so pages beyond the RAM mirror.
  assign dma_idx = ADDR_W'({page_q, idx_q});
  assign ram_idx = (state_q == S_READ) ? dma_idx : cpu_idx;
  // Old contents at the index; registered below, which gives read-first.
  assign ram_rd  = mem[ram_idx];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    parity_d   = ~parity_q;
    odd_d      = odd_q;
    page_d     = page_q;
    idx_d      = idx_q;
    oam_we_d   = 1'b0;
    oam_addr_d = oam_addr_q;
    oam_data_d = oam_data_q;
    rdata_d    = rdata_q;
    ram_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ram_we  = ~WE;
        rdata_d = ram_rd;
        if (dma_start) begin
          page_d  = dma_page;
          odd_d   = parity_q;
          idx_d   = '0;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        // An odd start spends one extra cycle here; odd_q doubles as the counter.
        if (odd_q) odd_d   = 1'b0;
        else       state_d = S_READ;
      end
      S_READ: begin
        rdata_d    = ram_rd;
        oam_data_d = ram_rd;
        oam_addr_d = idx_q;
        oam_we_d   = 1'b1;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_d = (state_d != S_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state_q    <= S_IDLE;
      parity_q   <= 1'b0;
      odd_q      <= 1'b0;
      page_q     <= '0;
      idx_q      <= '0;
      stall_q    <= 1'b0;
      oam_we_q   <= 1'b0;
      oam_addr_q <= '0;
      oam_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      parity_q   <= parity_d;
      odd_q      <= odd_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      stall_q    <= stall_d;
      oam_we_q   <= oam_we_d;
      oam_addr_q <= oam_addr_d;
      oam_data_q <= oam_data_d;
      rdata_q    <= rdata_d;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto a memory macro and keeps
  // its contents across Reset.
  always_ff @(posedge Clk) begin
    if (ram_we) mem[ram_idx] <= cpu_wdata;
  end

  assign cpu_rdata = rdata_q;
  assign cpu_stall = stall_q;
  assign oam_addr  = oam_addr_q;
  assign oam_data  = oam_data_q;
  assign oam_we    = oam_we_q;

endmodule

// File: tb/tb_cpu_ram_dma.sv
// Self-checking bench for cpu_ram_dma with default parameters. A byte array
// models the RAM; DMA behaviour is checked against the stall/strobe timing
// rules computed from the start parity.
module tb_cpu_ram_dma;

  localparam int LEN = 256;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] cpu_addr;
  logic        WE;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        dma_start;
  logic [7:0]  dma_page;
  logic        cpu_stall;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;

  cpu_ram_dma dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_addr  (cpu_addr),
    .WE        (WE),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .dma_start (dma_start),
    .dma_page  (dma_page),
    .cpu_stall (cpu_stall),
    .oam_addr  (oam_addr),
    .oam_data  (oam_data),
    .oam_we    (oam_we)
  );

  always #5 Clk = ~Clk;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;   // edges since reset release; parity = cyc % 2
  logic [7:0] model [2048];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    cyc++;
    #1;
  endtask

  function automatic logic [7:0] page_byte(input logic [7:0] page, input int n);
    logic [15:0] lin;
    lin = {page, 8'(n)};
    return model[lin[10:0]];
  endfunction

  // One CPU bus cycle; the read returns the contents before any same-edge write.
  task automatic cpu_cycle(input logic [15:0] a, input logic wr, input logic [7:0] d,
                           input bit chk);
    logic [7:0] exp;
    cpu_addr  = a;
    WE        = ~wr;
    cpu_wdata = d;
    dma_start = 1'b0;
    exp       = model[a[10:0]];
    step();
    if (wr) model[a[10:0]] = d;
    WE = 1'b1;
    if (chk) check("cpu_rdata", cpu_rdata, exp);
  endtask

  // Start a DMA on a cycle of the requested parity and follow it to the end.
  // abort_after > 0 pulses Reset once that many OAM bytes have been seen.
  task automatic run_dma(input logic [7:0] page, input bit want_odd, input bit disturb,
                         input int abort_after);
    int e, n, stall, first;
    bit odd;
    if ((cyc % 2) != int'(want_odd)) cpu_cycle(16'($urandom), 1'b0, 8'h00, 1'b1);
    odd       = bit'(cyc % 2);
    dma_page  = page;
    dma_start = 1'b1;
    WE        = 1'b1;
    step();
    dma_start = 1'b0;
    dma_page  = 8'($urandom);
    check("stall_rise", cpu_stall, 1);
    e = 0; n = 0; stall = 0; first = -1;
    while (cpu_stall && stall < 600) begin
      stall++;
      if (oam_we) begin
        if (first < 0) first = e;
        check("oam_addr", oam_addr, n);
        check("oam_data", oam_data, page_byte(page, n));
        check("dma_rdata", cpu_rdata, page_byte(page, n));
        check("we_spacing", e, first + 2 * n);
        n++;
        if (abort_after > 0 && n == abort_after) begin
          WE    = 1'b1;
          Reset = 1'b1;
          #2;
          check("abort_stall", cpu_stall, 0);
          check("abort_oam_we", oam_we, 0);
          check("abort_oam_addr", oam_addr, 0);
          check("abort_rdata", cpu_rdata, 0);
          Reset = 1'b0;
          cyc   = 0;
          return;
        end
      end
      if (disturb) begin
        WE        = 1'b0;
        cpu_addr  = 16'h0200;
        cpu_wdata = 8'h00;
        dma_start = 1'($urandom_range(0, 1));
      end
      step();
      e++;
    end
    WE        = 1'b1;
    dma_start = 1'b0;
    check("stall_cycles", stall, 1 + int'(odd) + 2 * LEN);
    check("oam_count", n, LEN);
    check("first_we", first, 2 + int'(odd));
  endtask

  initial begin
    Reset     = 1'b1;
    WE        = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    dma_start = 1'b0;
    dma_page  = '0;
    #12;
    check("rst_stall", cpu_stall, 0);
    check("rst_oam_we", oam_we, 0);
    check("rst_oam_addr", oam_addr, 0);
    check("rst_oam_data", oam_data, 0);
    check("rst_rdata", cpu_rdata, 0);
    Reset = 1'b0;
    cyc   = 0;

    // Fill the whole RAM through random mirrors so every word is defined.
    for (int i = 0; i < 2048; i++)
      cpu_cycle({5'($urandom), 11'(i)}, 1'b1, 8'($urandom), 1'b0);

    // Mirrored write/read.
    cpu_cycle(16'h0123, 1'b1, 8'hA5, 1'b1);
    cpu_cycle(16'h0923, 1'b0, 8'h00, 1'b1);
    check("mirror_const", cpu_rdata, 8'hA5);

    // Read-first on a same-cycle write.
    cpu_cycle(16'h0010, 1'b1, 8'h11, 1'b1);
    cpu_cycle(16'h0010, 1'b1, 8'h5A, 1'b1);
    check("rf_old", cpu_rdata, 8'h11);
    cpu_cycle(16'h0010, 1'b0, 8'h00, 1'b1);
    check("rf_new", cpu_rdata, 8'h5A);

    // Random CPU traffic.
    for (int i = 0; i < 200; i++)
      cpu_cycle(16'($urandom), 1'($urandom), 8'($urandom), 1'b1);

    // Page 2 holds i ^ 0xFF.
    for (int i = 0; i < 256; i++)
      cpu_cycle(16'h0200 + 16'(i), 1'b1, 8'(i) ^ 8'hFF, 1'b1);

    run_dma(8'h02, 1'b0, 1'b0, 0);
    run_dma(8'h02, 1'b1, 1'b0, 0);

    // CPU write attempts and extra start pulses while stalled are ignored.
    run_dma(8'h02, 1'($urandom), 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      cpu_cycle(16'h0200, 1'b0, 8'h00, 1'b1);
      check("no_requeue", cpu_stall, 0);
    end
    check("ram_0200", cpu_rdata, 8'hFF);

    // Random pages (mirrored) with random parity.
    for (int i = 0; i < 2; i++)
      run_dma(8'($urandom), 1'($urandom), 1'b0, 0);

    // Reset mid-DMA, then confirm the RAM survived.
    run_dma(8'h02, 1'b0, 1'b0, 40);
    for (int i = 0; i < 256; i++)
      cpu_cycle(16'h0200 + 16'(i), 1'b0, 8'h00, 1'b1);
    check("after_abort_stall", cpu_stall, 0);
    run_dma(8'h02, 1'b1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
